// File: rtl/hog_axil_regs.sv
// AXI4-Lite register file for the HOG accelerator: configuration, start pulse,
// sticky completion status and a level interrupt toward the PS.
module hog_axil_regs #(
    parameter int C_S_AXI_GP_DATA_WIDTH = 32,
    parameter int C_S_AXI_GP_ADDR_WIDTH = 5
) (
    input  logic                               s_axi_aclk,
    input  logic                               s_axi_aresetn,
    input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                         s_axi_awprot,
    input  logic                               s_axi_awvalid,
    output logic                               s_axi_awready,
    input  logic [C_S_AXI_GP_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_GP_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                               s_axi_wvalid,
    output logic                               s_axi_wready,
    output logic [1:0]                         s_axi_bresp,
    output logic                               s_axi_bvalid,
    input  logic                               s_axi_bready,
    input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                         s_axi_arprot,
    input  logic                               s_axi_arvalid,
    output logic                               s_axi_arready,
    output logic [C_S_AXI_GP_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                         s_axi_rresp,
    output logic                               s_axi_rvalid,
    input  logic                               s_axi_rready,
    output logic                               start_o,
    output logic [15:0]                        width_o,
    output logic [15:0]                        height_o,
    output logic [31:0]                        src_addr_o,
    output logic [31:0]                        dst_addr_o,
    output logic [7:0]                         cell_cfg_o,
    input  logic                               busy_i,
    input  logic                               done_i,
    output logic                               irq_o
);

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_WIDTH  = 3'd2;
    localparam logic [2:0] ADDR_HEIGHT = 3'd3;
    localparam logic [2:0] ADDR_SRC    = 3'd4;
    localparam logic [2:0] ADDR_DST    = 3'd5;
    localparam logic [2:0] ADDR_CELL   = 3'd6;
    localparam logic [2:0] ADDR_IRQ_EN = 3'd7;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic        aw_ready_q;
    logic        b_valid_q;
    logic [1:0]  b_resp_q;
    logic        ar_ready_q;
    logic        r_valid_q;
    logic [31:0] r_data_q;

    logic [15:0] width_q;
    logic [15:0] height_q;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [7:0]  cell_q;
    logic        irq_en_q;
    logic        done_q;
    logic        start_q;
    logic        irq_q;

    logic        wr_fire;
    logic        rd_fire;
    logic [2:0]  wr_idx;
    logic [2:0]  rd_idx;
    logic        wr_start;
    logic        wr_clear;
    logic        wr_slverr;
    logic        cfg_we;
    logic        irq_en_we;
    logic [31:0] cfg_old;
    logic [31:0] cfg_new;
    logic [31:0] rd_word;

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    // Both write channels are taken in the same cycle; a lone AW or W just waits.
    assign wr_fire = aw_ready_q & s_axi_awvalid & s_axi_wvalid;
    assign rd_fire = ar_ready_q & s_axi_arvalid;
    assign wr_idx  = s_axi_awaddr[4:2];
    assign rd_idx  = s_axi_araddr[4:2];

    always_comb begin
        wr_start  = 1'b0;
        wr_clear  = 1'b0;
        wr_slverr = 1'b0;
        cfg_we    = 1'b0;
        irq_en_we = 1'b0;
        if (wr_fire) begin
            unique case (wr_idx)
                ADDR_CTRL: begin
                    if (s_axi_wstrb[0] && s_axi_wdata[0]) begin
                        if (busy_i) wr_slverr = 1'b1;
                        else        wr_start  = 1'b1;
                    end
                end
                ADDR_STATUS: wr_clear  = s_axi_wstrb[0] & s_axi_wdata[1];
                ADDR_IRQ_EN: irq_en_we = s_axi_wstrb[0];
                default: begin
                    if (busy_i) wr_slverr = 1'b1;
                    else        cfg_we    = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        cfg_old = '0;
        case (wr_idx)
            ADDR_WIDTH:  cfg_old = {16'h0, width_q};
            ADDR_HEIGHT: cfg_old = {16'h0, height_q};
            ADDR_SRC:    cfg_old = src_q;
            ADDR_DST:    cfg_old = dst_q;
            ADDR_CELL:   cfg_old = {24'h0, cell_q};
            default:     cfg_old = '0;
        endcase
    end

    assign cfg_new = apply_strb(cfg_old, s_axi_wdata, s_axi_wstrb);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            width_q  <= '0;
            height_q <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            cell_q   <= '0;
        end else if (cfg_we) begin
            case (wr_idx)
                ADDR_WIDTH:  width_q  <= cfg_new[15:0];
                ADDR_HEIGHT: height_q <= cfg_new[15:0];
                ADDR_SRC:    src_q    <= cfg_new;
                ADDR_DST:    dst_q    <= cfg_new;
                ADDR_CELL:   cell_q   <= cfg_new[7:0];
                default:     ;
            endcase
        end
    end

    // A completion in the same cycle as a clear or a start must not be lost.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (irq_en_we) irq_en_q <= s_axi_wdata[0];
            if (done_i)                    done_q <= 1'b1;
            else if (wr_start || wr_clear) done_q <= 1'b0;
            start_q <= wr_start;
            irq_q   <= done_q & irq_en_q;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_ready_q <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            aw_ready_q <= ~aw_ready_q & ~b_valid_q & s_axi_awvalid & s_axi_wvalid;
            if (wr_fire) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= wr_slverr ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi_bready) begin
                b_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (rd_idx)
            ADDR_STATUS: rd_word = {30'h0, done_q, busy_i};
            ADDR_WIDTH:  rd_word = {16'h0, width_q};
            ADDR_HEIGHT: rd_word = {16'h0, height_q};
            ADDR_SRC:    rd_word = src_q;
            ADDR_DST:    rd_word = dst_q;
            ADDR_CELL:   rd_word = {24'h0, cell_q};
            ADDR_IRQ_EN: rd_word = {31'h0, irq_en_q};
            default:     rd_word = '0;
        endcase
    end

    // Read data is captured from pre-edge state, so a same-edge write is not visible.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
        end else begin
            ar_ready_q <= ~ar_ready_q & ~r_valid_q & s_axi_arvalid;
            if (rd_fire) begin
                r_valid_q <= 1'b1;
                r_data_q  <= rd_word;
            end else if (s_axi_rready) begin
                r_valid_q <= 1'b0;
            end
        end
    end

    assign s_axi_awready = aw_ready_q;
    assign s_axi_wready  = aw_ready_q;
    assign s_axi_bvalid  = b_valid_q;
    assign s_axi_bresp   = b_resp_q;
    assign s_axi_arready = ar_ready_q;
    assign s_axi_rvalid  = r_valid_q;
    assign s_axi_rdata   = r_data_q;
    assign s_axi_rresp   = RESP_OKAY;

    assign start_o    = start_q;
    assign irq_o      = irq_q;
    assign width_o    = width_q;
    assign height_o   = height_q;
    assign src_addr_o = src_q;
    assign dst_addr_o = dst_q;
    assign cell_cfg_o = cell_q;

endmodule

// File: tb/tb_hog_axil_regs.sv
// Scoreboard bench for hog_axil_regs: directed scenarios plus randomized
// traffic checked against a register-map model kept in plain arrays.
module tb_hog_axil_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [4:0]  s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        start_o;
    logic [15:0] width_o;
    logic [15:0] height_o;
    logic [31:0] src_addr_o;
    logic [31:0] dst_addr_o;
    logic [7:0]  cell_cfg_o;
    logic        busy_i;
    logic        done_i;
    logic        irq_o;

    hog_axil_regs dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .start_o       (start_o),
        .width_o       (width_o),
        .height_o      (height_o),
        .src_addr_o    (src_addr_o),
        .dst_addr_o    (dst_addr_o),
        .cell_cfg_o    (cell_cfg_o),
        .busy_i        (busy_i),
        .done_i        (done_i),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int start_cnt = 0;

    logic [1:0]  bq[$];
    logic [31:0] rq[$];

    // Reference model: register contents by word index, sticky done, expected start count.
    logic [31:0] m_reg [8];
    bit          m_done;
    int          start_exp = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_mask(input int idx);
        case (idx)
            2, 3:    return 32'h0000_FFFF;
            4, 5:    return 32'hFFFF_FFFF;
            6:       return 32'h0000_00FF;
            7:       return 32'h0000_0001;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [1:0] mdl_write(input int idx, input logic [31:0] d,
                                             input logic [3:0] s, input bit dn);
        logic [1:0]  resp;
        logic [31:0] bm;
        resp = 2'b00;
        bm = strb_mask(s);
        if (idx == 0) begin
            if (s[0] && d[0]) begin
                if (busy_i) resp = 2'b10;
                else begin
                    start_exp++;
                    m_done = 1'b0;
                end
            end
        end else if (idx == 1) begin
            if (s[0] && d[1]) m_done = 1'b0;
        end else if (idx == 7) begin
            m_reg[7] = ((m_reg[7] & ~bm) | (d & bm)) & reg_mask(7);
        end else if (busy_i) begin
            resp = 2'b10;
        end else begin
            m_reg[idx] = ((m_reg[idx] & ~bm) | (d & bm)) & reg_mask(idx);
        end
        if (dn) m_done = 1'b1;
        return resp;
    endfunction

    function automatic logic [31:0] mdl_read(input int idx);
        if (idx == 0) return 32'h0;
        if (idx == 1) return {30'h0, m_done, busy_i};
        return m_reg[idx];
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
        m_done = 1'b0;
    endtask

    always @(negedge clk) begin
        if (start_o) start_cnt++;
    end

    // Scoreboard monitor: compares every completed response against the queued expectation.
    always @(negedge clk) begin
        logic [1:0]  eb;
        logic [31:0] er;
        if (rst_n && s_axi_bvalid && s_axi_bready) begin
            chk("b_expected", 128'(bq.size() != 0), 128'(1));
            if (bq.size() != 0) begin
                eb = bq.pop_front();
                chk("bresp", 128'(s_axi_bresp), 128'(eb));
            end
        end
        if (rst_n && s_axi_rvalid && s_axi_rready) begin
            chk("r_expected", 128'(rq.size() != 0), 128'(1));
            if (rq.size() != 0) begin
                er = rq.pop_front();
                chk("rdata", 128'({s_axi_rresp, s_axi_rdata}), 128'({2'b00, er}));
            end
        end
    end

    task automatic check_state();
        chk("start_count", 128'(start_cnt), 128'(start_exp));
        chk("cfg_outputs", 128'({width_o, height_o, src_addr_o, dst_addr_o, cell_cfg_o}),
            128'({m_reg[2][15:0], m_reg[3][15:0], m_reg[4], m_reg[5], m_reg[6][7:0]}));
        chk("irq_level", 128'(irq_o), 128'(m_done & m_reg[7][0]));
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lag, input int b_hold, input bit with_done, input bit chk_end);
        int n;
        bq.push_back(mdl_write(int'(addr[4:2]), data, strb, with_done));
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        for (int i = 0; i < w_lag; i++) begin
            @(negedge clk);
            chk("aw_without_w", 128'(s_axi_awready), 128'(0));
            @(posedge clk); #1;
        end
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        s_axi_wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_awready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("aw_accept", 128'(s_axi_awready), 128'(1));
        chk("w_with_aw", 128'(s_axi_wready), 128'(1));
        if (with_done) done_i = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        done_i        = 1'b0;
        for (int i = 0; i < b_hold; i++) begin
            @(negedge clk);
            chk("bvalid_hold", 128'(s_axi_bvalid), 128'(1));
            chk("no_accept_while_bvalid", 128'(s_axi_awready), 128'(0));
            @(posedge clk); #1;
        end
        s_axi_bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_bvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bvalid_seen", 128'(s_axi_bvalid), 128'(1));
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        if (chk_end) check_state();
    endtask

    task automatic axi_read(input logic [4:0] addr, input bit use_exp, input logic [31:0] exp_in,
                            input int r_hold);
        int n;
        rq.push_back(use_exp ? exp_in : mdl_read(int'(addr[4:2])));
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_arready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ar_accept", 128'(s_axi_arready), 128'(1));
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        chk("arready_one_cycle", 128'(s_axi_arready), 128'(0));
        chk("rvalid_after_accept", 128'(s_axi_rvalid), 128'(1));
        for (int i = 0; i < r_hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rvalid_hold", 128'(s_axi_rvalid), 128'(1));
        end
        @(posedge clk); #1;
        s_axi_rready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_rvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rvalid_seen", 128'(s_axi_rvalid), 128'(1));
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
        m_done = 1'b1;
        @(posedge clk); #1;
        chk("irq_after_done", 128'(irq_o), 128'(m_done & m_reg[7][0]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] exp_old;
        logic [31:0] data;
        logic [4:0]  addr;

        rst_n = 1'b0;
        s_axi_awaddr = '0; s_axi_awprot = 3'b010; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = 3'b010; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        busy_i = 1'b0;
        done_i = 1'b0;
        mdl_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 128'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
                                   s_axi_rvalid, start_o, irq_o, s_axi_bresp, s_axi_rresp, s_axi_rdata}),
            128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_state();

        for (int i = 0; i < 8; i++) axi_read(5'(i * 4), 1'b0, 32'h0, 0);
        busy_i = 1'b1;
        axi_read(5'h04, 1'b0, 32'h0, 1);
        busy_i = 1'b0;

        axi_write(5'h08, 32'h0000_0280, 4'b0011, 0, 0, 1'b0, 1'b1);
        axi_write(5'h0C, 32'h0000_01E0, 4'b1111, 0, 0, 1'b0, 1'b1);
        axi_write(5'h10, 32'h1000_0000, 4'b1111, 0, 0, 1'b0, 1'b1);
        chk("width_640", 128'(width_o), 128'(640));
        chk("height_480", 128'(height_o), 128'(480));
        axi_read(5'h08, 1'b0, 32'h0, 0);
        axi_read(5'h0C, 1'b0, 32'h0, 0);
        axi_read(5'h11, 1'b0, 32'h0, 0);
        axi_write(5'h08, 32'h0000_FFFF, 4'b0001, 0, 0, 1'b0, 1'b1);
        chk("width_partial_strb", 128'(width_o), 128'(16'h02FF));
        axi_read(5'h08, 1'b0, 32'h0, 0);

        // AW leads W by 3 cycles, response held 4 cycles while a second write waits behind it.
        fork
            axi_write(5'h14, 32'hDEAD_BEEF, 4'hF, 3, 4, 1'b0, 1'b0);
            begin
                repeat (6) @(posedge clk);
                #1;
                axi_write(5'h18, 32'h0000_005A, 4'hF, 0, 0, 1'b0, 1'b0);
            end
        join
        check_state();

        axi_write(5'h00, 32'h0000_0001, 4'hF, 0, 0, 1'b0, 1'b1);
        chk("start_single_pulse", 128'(start_cnt), 128'(1));
        busy_i = 1'b1;
        axi_write(5'h00, 32'h0000_0001, 4'hF, 0, 0, 1'b0, 1'b1);
        axi_write(5'h08, 32'h0000_1234, 4'hF, 0, 0, 1'b0, 1'b1);
        chk("width_locked_busy", 128'(width_o), 128'(16'h02FF));
        busy_i = 1'b0;
        axi_read(5'h00, 1'b0, 32'h0, 0);

        axi_write(5'h1C, 32'h0000_0001, 4'hF, 0, 0, 1'b0, 1'b1);
        pulse_done();
        chk("irq_set", 128'(irq_o), 128'(1));
        axi_read(5'h04, 1'b0, 32'h0, 0);
        axi_write(5'h04, 32'h0000_0002, 4'hF, 0, 0, 1'b1, 1'b1);
        axi_read(5'h04, 1'b0, 32'h0, 0);
        axi_write(5'h04, 32'h0000_0002, 4'hF, 0, 0, 1'b0, 1'b1);
        chk("irq_cleared", 128'(irq_o), 128'(0));
        axi_read(5'h04, 1'b0, 32'h0, 0);

        exp_old = mdl_read(6);
        fork
            axi_write(5'h18, 32'h0000_00A5, 4'hF, 0, 0, 1'b0, 1'b1);
            axi_read(5'h18, 1'b1, exp_old, 0);
        join
        axi_read(5'h18, 1'b0, 32'h0, 0);

        for (int k = 0; k < 80; k++) begin
            busy_i = ($urandom_range(0, 3) == 0);
            addr = 5'($urandom_range(0, 31));
            data = $urandom;
            if ($urandom_range(0, 9) < 6)
                axi_write(addr, data, 4'($urandom), int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 2)), 1'b0, 1'b1);
            else
                axi_read(addr, 1'b0, 32'h0, int'($urandom_range(0, 2)));
            if ($urandom_range(0, 4) == 0) pulse_done();
        end
        busy_i = 1'b0;

        // Reset while a write response is pending: response must vanish, registers clear.
        s_axi_awaddr  = 5'h08;
        s_axi_wdata   = 32'h0000_1234;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_awready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_accept", 128'(s_axi_awready), 128'(1));
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        @(negedge clk);
        chk("bvalid_before_reset", 128'(s_axi_bvalid), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_outputs", 128'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
                                       s_axi_rvalid, start_o, irq_o, s_axi_bresp, s_axi_rdata}),
            128'(0));
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mdl_reset();
        @(posedge clk); #1;
        check_state();
        for (int i = 0; i < 8; i++) axi_read(5'(i * 4), 1'b0, 32'h0, 0);

        chk("bq_drained", 128'(bq.size()), 128'(0));
        chk("rq_drained", 128'(rq.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hog_axil_regs.md
# hog_axil_regs

AXI4-Lite GP slave register file for the HOG accelerator. Sits directly downstream of the GP AXI4-Lite port (5-bit address, 32-bit data) and converts PS register accesses into the configuration, start and status signals consumed by the HOG core. Fully synchronous to the AXI clock; a single outstanding read and a single outstanding write are supported.

## Interface
- C_S_AXI_GP_DATA_WIDTH, 32, register/data width (fixed; no other value supported)
- C_S_AXI_GP_ADDR_WIDTH, 5, byte address width; 8 word registers, address bits [1:0] ignored
- s_axi_aclk  in  1  clock; all logic rises on this edge
- s_axi_aresetn  in  1  asynchronous active-low reset
- s_axi_awaddr / s_axi_awprot / s_axi_awvalid  in  5 / 3 / 1  write address channel (awprot ignored)
- s_axi_awready  out  1  write address accept
- s_axi_wdata / s_axi_wstrb / s_axi_wvalid  in  32 / 4 / 1  write data channel
- s_axi_wready  out  1  write data accept
- s_axi_bresp / s_axi_bvalid  out  2 / 1  write response; s_axi_bready  in  1
- s_axi_araddr / s_axi_arprot / s_axi_arvalid  in  5 / 3 / 1  read address (arprot ignored)
- s_axi_arready  out  1  read address accept
- s_axi_rdata / s_axi_rresp / s_axi_rvalid  out  32 / 2 / 1  read data; s_axi_rready  in  1
- start_o  out  1  one-cycle start pulse to the HOG core
- width_o / height_o  out  16 / 16  image dimensions in pixels
- src_addr_o / dst_addr_o  out  32 / 32  HP-side DDR base addresses
- cell_cfg_o  out  8  cell size / bin configuration, passed through unchanged
- busy_i  in  1  core is processing
- done_i  in  1  one-cycle completion pulse from core
- irq_o  out  1  level interrupt = done_sticky & irq_en

## Operation
- Register map (word offset): 0x00 CTRL (bit0 START, write-only, reads 0); 0x04 STATUS (bit0 busy_i live, bit1 DONE sticky W1C, others 0); 0x08 WIDTH [15:0]; 0x0C HEIGHT [15:0]; 0x10 SRC_ADDR; 0x14 DST_ADDR; 0x18 CELL_CFG [7:0]; 0x1C IRQ_EN bit0.
- Unused bits read 0; writes to them are discarded.
- wstrb honoured per byte on all R/W registers; START and DONE-clear act only if wstrb[0]=1.
- Write to CTRL with bit0=1 while busy_i=0: start_o pulses, DONE cleared, bresp=OKAY.
- Write to CTRL with bit0=1 while busy_i=1: no pulse, bresp=SLVERR (2'b10).
- Write to 0x08–0x18 while busy_i=1: register unchanged, bresp=SLVERR. IRQ_EN and STATUS writable anytime.
- done_i sets DONE. Same-cycle done_i and W1C clear: set wins. Same-cycle done_i and START accept: set wins.
- All reads return OKAY; reading has no side effects.

## Timing
- Reset: all registers 0; awready, wready, bvalid, arready, rvalid, start_o, irq_o = 0; bresp, rresp, rdata = 0.
- Write: when awvalid & wvalid & !bvalid, awready and wready assert together for exactly one cycle; register update occurs on that same edge. AW without W (or vice versa) is not accepted; the other channel is waited for.
- bvalid asserts the cycle after accept, holds with stable bresp until bready; next write is not accepted while bvalid=1.
- start_o is high in the cycle after the accepting edge, for exactly one cycle.
- Read: arready pulses one cycle when arvalid & !rvalid; rvalid and rdata valid the next cycle, held stable until rready.
- Read and write may be accepted in the same cycle; a read of a register written on that edge returns the old value.
- irq_o registered: rises one cycle after DONE sets, falls one cycle after DONE cleared or IRQ_EN cleared.
- Reset asserted mid-transaction: all channels drop immediately; no response issued for the aborted transaction.

## Test plan
- Reset then read all 8 offsets -> every rdata 0x0 except STATUS=busy_i, rresp=OKAY, one-cycle arready each.
- Write WIDTH=0x0280 strb 4'b0011, HEIGHT=0x01E0, SRC=0x1000_0000 -> width_o=640, height_o=480, readback matches; partial strb 4'b0001 of 0xFFFF to WIDTH -> 0x02FF.
- AW presented 3 cycles before W, bready held low 4 cycles -> no accept until W arrives, bvalid held 4 cycles, no second accept meanwhile.
- Write CTRL=1 with busy_i=0 -> single start_o pulse, OKAY; repeat with busy_i=1 -> no pulse, SLVERR; write WIDTH while busy -> SLVERR, value unchanged.
- IRQ_EN=1, pulse done_i -> STATUS=0x2, irq_o=1; write STATUS=0x2 same cycle as done_i -> DONE stays 1; later write 0x2 alone -> irq_o=0.
- Assert aresetn low while bvalid=1 -> bvalid=0 immediately, all registers 0 after release.
